// File: rtl/exu_seq.sv
// exu_seq: multi-cycle fetch/exec/mem/wb sequencer owning the architectural PC.
// Define EXU_SEQ_PERF_EN to add the cycle_cnt/instret_cnt performance counters.
module exu_seq #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  input  logic        ifu_resp_valid,
  output logic [31:0] pc,
  output logic        exu_fire,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        ecall_taken,
  input  logic [31:0] ecall_target,
  input  logic        mret_taken,
  input  logic [31:0] mret_target,
  input  logic        ebreak_en,
  output logic        lsu_req_valid,
  input  logic        lsu_req_ready,
  input  logic        lsu_resp_valid,
  output logic        rf_we,
  output logic        halt,
  output logic        err
`ifdef EXU_SEQ_PERF_EN
  ,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT_I,
    S_EXEC,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] next_pc_q;
  logic        wb_en_q;
  logic        err_q;
  logic        err_set;
  logic [7:0]  wait_cnt_q;
  logic [31:0] tgt;
  logic        redir;
  logic        tmo;
  logic        waiting;

  assign redir = ecall_taken | mret_taken | branch_taken;
  assign tmo   = (wait_cnt_q == TMO_LAST);

  assign waiting = (state_q == S_FETCH) || (state_q == S_WAIT_I) ||
                   (state_q == S_MEM_REQ) || (state_q == S_MEM_WAIT);

  always_comb begin
    tgt = pc_q + 32'd4;
    if (ebreak_en)         tgt = pc_q;
    else if (ecall_taken)  tgt = ecall_target;
    else if (mret_taken)   tgt = mret_target;
    else if (branch_taken) tgt = branch_target;
  end

  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (ifu_req_ready) state_d = S_WAIT_I;
        else if (tmo) begin
          state_d = S_HALT;
          err_set = 1'b1;
        end
      end
      S_WAIT_I: begin
        if (ifu_resp_valid) state_d = S_EXEC;
        else if (tmo) begin
          state_d = S_HALT;
          err_set = 1'b1;
        end
      end
      S_EXEC: begin
        if (ebreak_en) state_d = S_HALT;
        else if (redir && (tgt[1:0] != 2'b00)) begin
          state_d = S_HALT;
          err_set = 1'b1;
        end
        else if (is_load | is_store) state_d = S_MEM_REQ;
        else state_d = S_WB;
      end
      S_MEM_REQ: begin
        if (lsu_req_ready) state_d = S_MEM_WAIT;
        else if (tmo) begin
          state_d = S_HALT;
          err_set = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (lsu_resp_valid) state_d = S_WB;
        else if (tmo) begin
          state_d = S_HALT;
          err_set = 1'b1;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      next_pc_q  <= RESET_PC;
      wb_en_q    <= 1'b0;
      err_q      <= 1'b0;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q <= state_d;
      err_q   <= err_q | err_set;
      if (state_d != state_q) wait_cnt_q <= 8'd0;
      else if (waiting)       wait_cnt_q <= wait_cnt_q + 8'd1;
      if (state_q == S_EXEC) begin
        next_pc_q <= tgt;
        wb_en_q   <= !(is_store | ecall_taken | mret_taken | ebreak_en);
      end
      if (state_q == S_WB) pc_q <= next_pc_q;
    end
  end

`ifdef EXU_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= 64'd0;
      instret_cnt <= 64'd0;
    end else begin
      if (state_q != S_HALT) cycle_cnt   <= cycle_cnt + 64'd1;
      if (state_q == S_WB)   instret_cnt <= instret_cnt + 64'd1;
    end
  end
`endif

  assign pc            = pc_q;
  assign ifu_req_valid = (state_q == S_FETCH);
  assign exu_fire      = (state_q == S_EXEC);
  assign lsu_req_valid = (state_q == S_MEM_REQ);
  assign rf_we         = (state_q == S_WB) & wb_en_q;
  assign halt          = (state_q == S_HALT);
  assign err           = err_q;

endmodule

// File: doc/exu_seq.md
# exu_seq

Multi-cycle instruction sequencer for the single-issue core. It owns the architectural PC and steps each instruction through fetch, execute, optional memory access and writeback using valid/ready handshakes with the IFU and LSU. It selects the next PC from the EXU redirect outputs (branch, ECALL, MRET) and produces a one-cycle `exu_fire` strobe that gates EXU CSR/trap updates. It halts on EBREAK, misaligned redirect targets, or handshake timeout.

## Interface
Parameters:
- `RESET_PC`, default 32'h8000_0000: PC value after reset.
- `TIMEOUT`, default 255: maximum cycles spent waiting in any handshake state. Legal range 1..255; the wait counter is 8 bits.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `ifu_req_valid` in/out: out  1  fetch request for address `pc`.
- `ifu_req_ready`  in  1  IFU accepts the request.
- `ifu_resp_valid`  in  1  instruction delivered to the IDU; decode/EXU inputs are valid from the next cycle.
- `pc`  out  32  current instruction address.
- `exu_fire`  out  1  one-cycle execute strobe; EXU CSR, ECALL and register-state updates are qualified by it.
- `is_load`, `is_store`  in  1 each  decoded memory-access class.
- `branch_taken`  in  1; `branch_target`  in  32.
- `ecall_taken`  in  1; `ecall_target`  in  32.
- `mret_taken`  in  1; `mret_target`  in  32.
- `ebreak_en`  in  1  EBREAK decoded.
- `lsu_req_valid`  out  1; `lsu_req_ready`  in  1; `lsu_resp_valid`  in  1.
- `rf_we`  out  1  register-file write strobe.
- `halt`  out  1  sticky halt.
- `err`  out  1  sticky; set only when the halt is abnormal.
- `cycle_cnt`, `instret_cnt`  out  64 each  performance counters; present only under `EXU_SEQ_PERF_EN`.

## Operation
FSM states: FETCH, WAIT_I, EXEC, MEM_REQ, MEM_WAIT, WB, HALT.
- **FETCH**
  - `ifu_req_valid`=1.
  - `ifu_req_ready`=1 → WAIT_I.
  - `ifu_resp_valid` is ignored in this state.
- **WAIT_I**: `ifu_resp_valid`=1 → EXEC.
- **EXEC** (exactly one cycle)
  - `exu_fire`=1.
  - Latches `next_pc` with this priority: ebreak > ecall_taken (ecall_target) > mret_taken (mret_target) > branch_taken (branch_target) > pc+4. All arithmetic is 32-bit and wraps modulo 2^32.
  - Latches `wb_en` = !(is_store | ecall_taken | mret_taken | ebreak_en).
  - Transitions, in priority order:
    - ebreak_en → HALT with err=0.
    - Selected redirect target with bits[1:0]≠0 → HALT with err=1.
    - is_load|is_store → MEM_REQ.
    - Otherwise → WB.
- **MEM_REQ**
  - `lsu_req_valid`=1 and held until `lsu_req_ready`=1 → MEM_WAIT.
  - `lsu_resp_valid` is ignored in this state.
- **MEM_WAIT**: `lsu_resp_valid`=1 → WB.
- **WB** (one cycle)
  - `rf_we`=`wb_en`.
  - `pc`<=`next_pc`.
  - Instruction retires.
  - → FETCH.
- **HALT**
  - Absorbing; only reset leaves it.
  - `pc` holds the address of the halting instruction.
  - All strobes are 0.
- **Timeout**
  - An 8-bit wait counter clears on every state transition and increments each cycle spent in FETCH, WAIT_I, MEM_REQ or MEM_WAIT.
  - When it reaches `TIMEOUT` without the awaited handshake → HALT with err=1.
  - A handshake arriving in the same cycle as the counter reaching `TIMEOUT` wins.
- `ifu_req_valid` and `lsu_req_valid` are never dropped before ready, except on timeout or reset.

## Timing
- **Reset values**
  - state=FETCH, pc=`RESET_PC`.
  - `ifu_req_valid`=1 (combinational from state); all other outputs 0.
  - Counters = 0.
  - Asserting `rst` mid-instruction aborts it immediately; there is no partial retire.
- **Latency**
  - All outputs are Moore, decoded from state, except `rf_we`, which is registered `wb_en` qualified by WB.
  - Non-memory instruction with zero-wait handshakes: 4 cycles (FETCH, WAIT_I, EXEC, WB).
  - Load/store with zero-wait handshakes: 6 cycles.
  - Each wait cycle adds one.
- `pc` updates only on the clock edge that leaves WB.
- Redirect inputs are sampled only in EXEC.

## Configuration
- `EXU_SEQ_PERF_EN` defined:
  - `cycle_cnt` increments on every clock when not in HALT.
  - `instret_cnt` increments on each WB exit.
  - Both are 64-bit, wrap, and reset to 0.
- Macro undefined: both ports and counters are absent. All other behaviour is identical.

## Test plan
- **Straight-line execution**: reset, IFU ready/resp same cycle, three ALU instructions → pc 8000_0000 → …04 → …08 → …0C; `rf_we` pulses once per instruction at cycles 4, 8, 12.
- **Branch and ECALL**
  - Branch at 8000_0000 with branch_taken=1, target 8000_0040 → next fetch at 8000_0040.
  - ecall_taken=1 with branch_taken=1 → pc=ecall_target, `rf_we`=0, `exu_fire` high exactly 1 cycle.
- **Load with wait states**: is_load=1, `lsu_req_ready` delayed 3 cycles and `lsu_resp_valid` delayed 2 more → `lsu_req_valid` held 4 cycles; retire at cycle 11; `rf_we`=1. A store under the same waits → `rf_we`=0.
- **EBREAK**: EBREAK at 8000_0010 → halt=1, err=0, pc=8000_0010. No further `ifu_req_valid` for 100 cycles.
- **Timeout**: `ifu_req_ready` held 0 with TIMEOUT=255 → halt=1 and err=1 on the 255th FETCH cycle. Repeat with ready arriving on that same cycle → normal progress.
- **Async reset mid-operation and counters**: assert `rst` low mid-MEM_WAIT → pc=`RESET_PC`, state FETCH, no `rf_we`. With `EXU_SEQ_PERF_EN` defined, after 3 ALU instructions instret_cnt=3 and cycle_cnt=12.
